fifo_word_packer: RTL and testbench
===================================

# fifo_word_packer

Downstream drain stage for the 8-bit synchronous FIFO. It pops bytes through the FIFO read port and packs every NBYTES consecutive bytes into one word, little-endian. The word goes out on a valid/ready port to the wide datapath. A flush request emits any partial word, zero-padded and marked by a byte-keep mask.

## Interface
Parameters:
- NBYTES, 4: bytes per output word; legal range 2..8.
- BYTE_W, 8: FIFO data width; must equal the FIFO `data_out` width.

Ports:
- clk  input  1  single clock; shared with the FIFO.
- rst_n  input  1  asynchronous, active-low reset; shared with the FIFO.
- fifo_rd  output  1  FIFO read strobe (drives FIFO `rd`).
- fifo_data  input  BYTE_W  FIFO `data_out`; valid the cycle after an accepted `fifo_rd`.
- fifo_empty  input  1  FIFO `empty`.
- flush  input  1  one-cycle pulse; emit the partial word.
- out_data  output  NBYTES*BYTE_W  packed word; byte 0 (first popped) is in bits [BYTE_W-1:0].
- out_keep  output  NBYTES  per-byte valid mask; all ones for a full word.
- out_valid  output  1  word available.
- out_ready  input  1  sink accepts the word when `out_valid && out_ready`.

## Operation
- Registered state:
  - `cnt` (0..NBYTES): bytes held in the assembly register.
  - `pend`: a read was issued last cycle.
  - `flush_req`: latched flush.
  - Output register: `out_data`, `out_keep`, `out_valid`.
- `fifo_rd = !fifo_empty && !flush_req && !flush && (cnt + pend < NBYTES)`. It is combinational from registered state and inputs.
- `pend <= fifo_rd`. When `pend` is 1, `fifo_data` is written into byte lane `cnt` at the clock edge and `cnt` increments.
- States:
  - FILL: normal accumulation.
  - STALL: `cnt == NBYTES`, waiting for the output slot. No reads are issued in STALL.
  - FLUSH: `flush_req` is set, waiting for `pend` to clear and the output slot to free.
- Output load: the word moves from assembly to output when it is complete and the slot is free (`!out_valid || out_ready`). In that case:
  - Assembly lanes and `cnt` clear to 0.
  - `out_keep` is set to all ones.
  - The load may occur on the same edge as the capture of byte NBYTES-1. The packer then goes straight FILL to FILL.
  - If the slot is not free, the packer enters STALL and loads on the first edge where `out_ready` is high.
- A handshake with no pending load clears `out_valid`.
- Flush:
  - A `flush` pulse sets `flush_req`.
  - Once `pend == 0` and the slot is free:
    - If `cnt > 0`: load the partial word with unused lanes set to 0 and `out_keep = (1<<cnt)-1`.
    - Then clear `cnt` and `flush_req`.
    - If `cnt == 0`: `flush_req` clears with no output.
  - A `flush` pulse while `flush_req` is already set is ignored.
- Reset (asynchronous, at any time):
  - `out_valid=0`, `out_data=0`, `out_keep=0`, `cnt=0`, `pend=0`, `flush_req=0`, so `fifo_rd=0`.
  - An in-flight byte is discarded; the FIFO is reset by the same `rst_n`.
- Width rules:
  - `cnt` is $clog2(NBYTES+1) bits.
  - The comparison `cnt + pend` is computed one bit wider so it cannot wrap.

## Timing
- FIFO read latency is 1. A `fifo_rd` high in cycle t with `!fifo_empty` presents the byte in t+1; the packer captures it at the end of t+1.
- Back-to-back reads are allowed while `cnt + pend < NBYTES`.
- First-word latency: `fifo_rd` first high in cycle 0 → `out_valid` high in cycle NBYTES+1 (cycle 5 for NBYTES=4).
- Sustained throughput with `out_ready` tied high is one word per NBYTES+1 cycles. The single bubble is the cycle holding the last pending byte.
- `out_data` and `out_keep` are stable while `out_valid && !out_ready`.
- `out_valid` never falls without a handshake, except on reset.
- The FIFO `empty` flag may fall at any point. The packer simply pauses with `cnt` preserved; there is no timeout.

## Structure
- Shared package `fifo_pkg`:
  - `BYTE_W` constant.
  - `pack_state_e` enum (FILL, STALL, FLUSH).
  - Helper function `keep_mask(cnt)`.
- Single module. No sub-module is required. The output register is small enough to live inline.
- The bench reuses the existing `fifo_if` for the FIFO side and adds a packer-side interface for the out_* signals.

## Test plan
- Bytes 0x11,0x22,0x33,0x44 pushed, `out_ready=1` → one word 0x44332211 with `keep=4'hF`; `out_valid` high exactly at cycle 5 after the first `fifo_rd`.
- 12 bytes 0x00..0x0B streamed, `out_ready=1` → words 0x03020100, 0x07060504, 0x0B0A0908, spaced 5 cycles apart.
- 8 bytes 0xA0..0xA7 with `out_ready=0` for 20 cycles:
  - first word 0xA3A2A1A0 held stable;
  - `cnt` stops at 4 with `fifo_rd=0`;
  - after `out_ready=1`, 0xA7A6A5A4 follows on the next handshake.
- 2 bytes 0xBE,0xEF then `flush` → 0x0000EFBE with `keep=4'h3`. A second `flush` with `cnt=0` → no output.
- `flush` pulsed in the same cycle as `pend=1` (byte 0xCC in flight) → the byte is captured first; output 0x000000CC with `keep=4'h1`.
- `rst_n` asserted mid-word (`cnt=2`, `pend=1`, `out_valid=1`) → all outputs 0 asynchronously; after release, a fresh 4-byte sequence packs correctly with no stale lanes.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the byte FIFO and its downstream word packer.
//   BYTE_W       : FIFO data width in bits
//   pack_state_e : packer control state (FILL, STALL, FLUSH)
//   keep_mask    : byte-keep mask with the low 'cnt' lanes set (up to 8 lanes)
package fifo_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      FILL  = 2'd0,   // accumulating bytes
      STALL = 2'd1,   // assembly full, waiting for the output slot
      FLUSH = 2'd2    // flush latched, waiting for in-flight byte and slot
   } pack_state_e;

   function automatic logic [7:0] keep_mask(input logic [3:0] cnt);
      logic [8:0] m;
      m = (9'd1 << cnt) - 9'd1;
      return m[7:0];
   endfunction

endpackage

// File: rtl/fifo_word_packer.sv
// Drains an 8-bit synchronous FIFO (read latency 1) and packs every NBYTES
// consecutive bytes into one little-endian word presented on a valid/ready
// output port. A flush pulse emits any partial word, zero-padded, with a
// byte-keep mask marking the lanes that hold data.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset (shared with the FIFO)
//   fifo_rd     : FIFO read strobe
//   fifo_data   : FIFO read data, valid the cycle after an accepted fifo_rd
//   fifo_empty  : FIFO empty flag
//   flush       : one-cycle pulse, emit the partial word
//   out_data    : packed word, first popped byte in bits [BYTE_W-1:0]
//   out_keep    : per-byte valid mask, all ones for a full word
//   out_valid   : word available
//   out_ready   : sink accepts the word when out_valid && out_ready
//   dbg_state   : current control state (pack_state_e encoding)
//
// Output handshake: out_valid, once high, stays high with out_data/out_keep
// stable until the cycle where out_ready is also high; that cycle transfers
// the word. A new word may be loaded on the same edge as the transfer.
//
// NBYTES must lie in 2..8 (keep_mask covers at most 8 lanes).
module fifo_word_packer #(
   parameter int NBYTES = 4,
   parameter int BYTE_W = fifo_pkg::BYTE_W
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     fifo_rd,
   input  logic [BYTE_W-1:0]        fifo_data,
   input  logic                     fifo_empty,
   input  logic                     flush,
   output logic [NBYTES*BYTE_W-1:0] out_data,
   output logic [NBYTES-1:0]        out_keep,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [1:0]               dbg_state
);

   import fifo_pkg::*;

   localparam int CW = $clog2(NBYTES + 1);
   localparam int DW = NBYTES * BYTE_W;

   // Registered state
   logic [CW-1:0]                  cnt;
   logic                           pend;
   logic                           flush_req;
   logic [NBYTES-1:0][BYTE_W-1:0]  asm_q;
   pack_state_e                    state;

   // Next-state values
   logic [CW-1:0]                  cnt_n;
   logic                           flush_req_n;
   logic [NBYTES-1:0][BYTE_W-1:0]  asm_n;
   logic [DW-1:0]                  out_data_n;
   logic [NBYTES-1:0]              out_keep_n;
   logic                           out_valid_n;
   pack_state_e                    state_n;

   logic [CW:0]                    fill_level;
   logic                           slot_free;
   logic [7:0]                     km;

   // Bytes held plus the one in flight; one bit wider so it cannot wrap.
   assign fill_level = {1'b0, cnt} + {{CW{1'b0}}, pend};
   assign slot_free  = !out_valid || out_ready;
   assign fifo_rd    = !fifo_empty && !flush_req && !flush &&
                       (fill_level < (CW+1)'(NBYTES));
   assign dbg_state  = state;

   always_comb begin
      cnt_n       = cnt;
      asm_n       = asm_q;
      flush_req_n = flush_req || flush;
      out_data_n  = out_data;
      out_keep_n  = out_keep;
      out_valid_n = out_valid;
      km          = keep_mask(4'(cnt));

      // Capture the byte requested last cycle into lane 'cnt'.
      if (pend) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (cnt == CW'(i)) asm_n[i] = fifo_data;
         end
         cnt_n = cnt + CW'(1);
      end

      if (cnt_n == CW'(NBYTES) && slot_free) begin
         // Full word: may coincide with the capture of the last byte.
         out_data_n  = asm_n;
         out_keep_n  = '1;
         out_valid_n = 1'b1;
         asm_n       = '0;
         cnt_n       = '0;
      end else if (flush_req && !pend && slot_free) begin
         // Lanes at and above cnt are still zero from the last clear.
         if (cnt != '0) begin
            out_data_n  = asm_q;
            out_keep_n  = km[NBYTES-1:0];
            out_valid_n = 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid_n = 1'b0;
         end
         asm_n       = '0;
         cnt_n       = '0;
         flush_req_n = 1'b0;
      end else if (out_valid && out_ready) begin
         out_valid_n = 1'b0;
      end

      if (flush_req_n)                  state_n = FLUSH;
      else if (cnt_n == CW'(NBYTES))    state_n = STALL;
      else                              state_n = FILL;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt       <= '0;
         pend      <= 1'b0;
         flush_req <= 1'b0;
         asm_q     <= '0;
         out_data  <= '0;
         out_keep  <= '0;
         out_valid <= 1'b0;
         state     <= FILL;
      end else begin
         cnt       <= cnt_n;
         pend      <= fifo_rd;
         flush_req <= flush_req_n;
         asm_q     <= asm_n;
         out_data  <= out_data_n;
         out_keep  <= out_keep_n;
         out_valid <= out_valid_n;
         state     <= state_n;
      end
   end

endmodule

// File: tb/tb_fifo_word_packer.sv
module tb_fifo_word_packer;

   localparam int NB = 4;
   localparam int DW = NB * 8;
   localparam int EW = NB + DW;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_rd;
   logic [7:0]    fifo_data;
   logic          fifo_empty;
   logic          flush = 1'b0;
   logic [DW-1:0] out_data;
   logic [NB-1:0] out_keep;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [1:0]    dbg_state;

   fifo_word_packer #(.NBYTES(NB), .BYTE_W(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_rd    (fifo_rd),
      .fifo_data  (fifo_data),
      .fifo_empty (fifo_empty),
      .flush      (flush),
      .out_data   (out_data),
      .out_keep   (out_keep),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- FIFO model (read latency 1) ----------------
   logic [7:0] mem [0:63];
   int wr_ptr = 0;
   int rd_ptr = 0;
   assign fifo_empty = (rd_ptr == wr_ptr);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr    <= wr_ptr;
         fifo_data <= '0;
      end else if (fifo_rd && !fifo_empty) begin
         fifo_data <= mem[rd_ptr % 64];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // ---------------- checking ----------------
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] b);
      mem[wr_ptr % 64] = b;
      wr_ptr++;
   endtask

   task automatic pulse_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
   endtask

   // ---------------- scoreboard ----------------
   logic [EW-1:0] exp_q[$];
   int hs_n = 0;

   task automatic expect_word(input logic [DW-1:0] d, input logic [NB-1:0] k);
      exp_q.push_back({k, d});
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         logic [EW-1:0] e;
         hs_n++;
         if (exp_q.size() == 0) begin
            chk("unexpected_word", {out_keep, out_data}, 64'hdead);
         end else begin
            e = exp_q.pop_front();
            chk("word_data", out_data, e[DW-1:0]);
            chk("word_keep", out_keep, e[EW-1:DW]);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      int t_hs [3];
      int hs0;
      logic [DW-1:0] snap;
      bit found;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", out_valid, 0);
      chk("rst_data",  out_data,  0);
      chk("rst_keep",  out_keep,  0);
      chk("rst_rd",    fifo_rd,   0);
      tick();
      rst_n = 1'b1;
      repeat (2) tick();

      // 1: single word, first-word latency
      out_ready = 1'b1;
      expect_word(32'h44332211, 4'hF);
      push(8'h11); push(8'h22); push(8'h33); push(8'h44);
      @(negedge clk);
      chk("t1_rd_cycle0", fifo_rd, 1);
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (out_valid) begin k = i; break; end
      end
      chk("t1_latency", k, 5);
      repeat (3) tick();
      chk("t1_valid_drop", out_valid, 0);
      chk("t1_sb_empty", exp_q.size(), 0);

      // 2: 12-byte stream, words 5 cycles apart
      expect_word(32'h03020100, 4'hF);
      expect_word(32'h07060504, 4'hF);
      expect_word(32'h0B0A0908, 4'hF);
      for (int i = 0; i < 12; i++) push(8'(i));
      for (int w = 0; w < 3; w++) begin
         t_hs[w] = -100;
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) begin t_hs[w] = cyc; break; end
         end
      end
      chk("t2_gap01", t_hs[1] - t_hs[0], 5);
      chk("t2_gap12", t_hs[2] - t_hs[1], 5);
      repeat (2) tick();
      chk("t2_sb_empty", exp_q.size(), 0);

      // 3: backpressure, output held stable, assembly stalls full
      out_ready = 1'b0;
      expect_word(32'hA3A2A1A0, 4'hF);
      expect_word(32'hA7A6A5A4, 4'hF);
      for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
      repeat (8) @(negedge clk);
      snap = out_data;
      chk("t3_valid_early", out_valid, 1);
      chk("t3_data_early", snap, 32'hA3A2A1A0);
      repeat (12) @(negedge clk);
      chk("t3_valid_late", out_valid, 1);
      chk("t3_data_late", out_data, 32'hA3A2A1A0);
      chk("t3_cnt_full", dut.cnt, 4);
      chk("t3_rd_off", fifo_rd, 0);
      chk("t3_state_stall", dbg_state, 2'd1);
      tick();
      out_ready = 1'b1;
      repeat (4) tick();
      chk("t3_sb_empty", exp_q.size(), 0);
      chk("t3_valid_drop", out_valid, 0);

      // 4: partial flush, then flush with nothing held
      expect_word(32'h0000EFBE, 4'h3);
      push(8'hBE); push(8'hEF);
      repeat (5) tick();
      hs0 = hs_n;
      pulse_flush();
      repeat (5) tick();
      chk("t4_one_word", hs_n - hs0, 1);
      hs0 = hs_n;
      pulse_flush();
      repeat (5) tick();
      chk("t4_no_word", hs_n - hs0, 0);
      chk("t4_flush_clear", dut.flush_req, 0);
      chk("t4_sb_empty", exp_q.size(), 0);

      // 5: flush while a byte is in flight
      expect_word(32'h000000CC, 4'h1);
      push(8'hCC);
      tick();
      chk("t5_pend", dut.pend, 1);
      pulse_flush();
      repeat (5) tick();
      chk("t5_sb_empty", exp_q.size(), 0);

      // 6: asynchronous reset mid-word
      out_ready = 1'b0;
      for (int i = 0; i < 7; i++) push(8'h50 + 8'(i));
      found = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (dut.cnt == 2 && dut.pend && out_valid) begin found = 1'b1; break; end
      end
      chk("t6_reached_mid", found, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", out_valid, 0);
      chk("t6_rst_data",  out_data,  0);
      chk("t6_rst_keep",  out_keep,  0);
      chk("t6_rst_rd",    fifo_rd,   0);
      chk("t6_rst_cnt",   dut.cnt,   0);
      tick();
      rst_n = 1'b1;
      out_ready = 1'b1;
      expect_word(32'h04030201, 4'hF);
      hs0 = hs_n;
      push(8'h01); push(8'h02); push(8'h03); push(8'h04);
      repeat (8) tick();
      chk("t6_one_word", hs_n - hs0, 1);
      chk("t6_sb_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Hard stop in case something above never returns.
   initial begin
      #100000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1);
   end

endmodule
